// File: rtl/stage_instruction_fetch_pkg.sv
// Shared types and constants for the instruction fetch stage.
// No logic or latency of its own; it has no flow control.
package stage_instruction_fetch_pkg;

    localparam logic [31:0] NOP_INSTRUCTION  = 32'h0000_0013;
    localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instruction;
    } fetch_entry_t;

    function automatic logic [31:0] word_align(input logic [31:0] addr);
        return addr & 32'hFFFF_FFFC;
    endfunction

endpackage

// File: rtl/fetch_queue.sv
// Synchronous FIFO of fetch entries; pushed data is visible at head one cycle after the push.
// The caller must not push when full; flush beats a push or pop in the same cycle.
module fetch_queue
    import stage_instruction_fetch_pkg::*;
#(
    parameter  int DEPTH = 2,
    localparam int PTR_W = $clog2(DEPTH),
    localparam int CNT_W = PTR_W + 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             flush,
    input  logic             push,
    input  fetch_entry_t     push_entry,
    input  logic             pop,
    output fetch_entry_t     head,
    output logic [CNT_W-1:0] count,
    output logic             empty,
    output logic             full
);

    fetch_entry_t     mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign empty   = (count == '0);
    assign full    = (count == CNT_W'(DEPTH));
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign head    = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (reset || flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            count <= count + CNT_W'(do_push) - CNT_W'(do_pop);
        end
    end

    always_ff @(posedge clk) begin
        if (do_push && !flush) mem[wr_ptr] <= push_entry;
    end

endmodule

// File: rtl/stage_instruction_fetch.sv
// Fetch stage: PC/request generation, response tracking and the IF/ID register.
// Latency is one cycle from rvalid to IF/ID; requests are credit-limited so the fetch queue never overflows.
module stage_instruction_fetch
    import stage_instruction_fetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC    = RESET_PC_DEFAULT,
    parameter int          QUEUE_DEPTH = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        stall,
    input  logic        branch_decision,
    input  logic [31:0] branch_target,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_gnt,
    input  logic        imem_rvalid,
    input  logic [31:0] imem_rdata,
    output logic        if_id_valid,
    output logic [31:0] if_id_pc,
    output logic [31:0] if_id_instruction
);

    localparam int CNT_W = $clog2(QUEUE_DEPTH) + 1;

    logic [31:0]      fetch_pc;
    logic [31:0]      resp_pc;
    logic [CNT_W-1:0] outstanding;
    logic [CNT_W-1:0] outstanding_next;
    logic [CNT_W-1:0] drop_cnt;
    logic [CNT_W:0]   in_flight;

    logic             grant;
    logic             keep;
    logic             redirect;
    logic             advance;
    logic             bypass;

    fetch_entry_t     q_head;
    fetch_entry_t     q_push_entry;
    logic [CNT_W-1:0] q_count;
    logic             q_empty;
    logic             q_full;
    logic             q_push;
    logic             q_pop;

    // Buffered words plus words still in flight are the credits against the queue.
    assign in_flight = {1'b0, q_count} + {1'b0, outstanding};
    assign imem_req  = !reset && (in_flight < (CNT_W + 1)'(QUEUE_DEPTH));
    assign imem_addr = fetch_pc;

    assign grant    = imem_req && imem_gnt;
    assign keep     = imem_rvalid && (drop_cnt == '0);
    assign redirect = branch_decision && !stall;
    assign advance  = !stall && !redirect;
    assign bypass   = advance && q_empty && keep;

    assign q_push       = keep && !redirect && !bypass;
    assign q_pop        = advance && !q_empty;
    assign q_push_entry = '{pc: resp_pc, instruction: imem_rdata};

    assign outstanding_next = outstanding + CNT_W'(grant) - CNT_W'(imem_rvalid);

    fetch_queue #(
        .DEPTH(QUEUE_DEPTH)
    ) u_fetch_queue (
        .clk       (clk),
        .reset     (reset),
        .flush     (redirect),
        .push      (q_push),
        .push_entry(q_push_entry),
        .pop       (q_pop),
        .head      (q_head),
        .count     (q_count),
        .empty     (q_empty),
        .full      (q_full)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            fetch_pc          <= RESET_PC;
            resp_pc           <= RESET_PC;
            outstanding       <= '0;
            drop_cnt          <= '0;
            if_id_valid       <= 1'b0;
            if_id_pc          <= '0;
            if_id_instruction <= NOP_INSTRUCTION;
        end else begin
            outstanding <= outstanding_next;
            if (redirect) begin
                // Every word still owed by memory after this edge belongs to the old path.
                fetch_pc          <= word_align(branch_target);
                resp_pc           <= word_align(branch_target);
                drop_cnt          <= outstanding_next;
                if_id_valid       <= 1'b0;
                if_id_instruction <= NOP_INSTRUCTION;
            end else begin
                if (grant) fetch_pc <= fetch_pc + 32'd4;
                if (keep)  resp_pc  <= resp_pc + 32'd4;
                if (imem_rvalid && (drop_cnt != '0)) drop_cnt <= drop_cnt - 1'b1;
                if (advance) begin
                    if (!q_empty) begin
                        if_id_valid       <= 1'b1;
                        if_id_pc          <= q_head.pc;
                        if_id_instruction <= q_head.instruction;
                    end else if (keep) begin
                        if_id_valid       <= 1'b1;
                        if_id_pc          <= resp_pc;
                        if_id_instruction <= imem_rdata;
                    end else begin
                        if_id_valid       <= 1'b0;
                        if_id_instruction <= NOP_INSTRUCTION;
                    end
                end
            end
        end
    end

    a_no_overflow: assert property (@(posedge clk) disable iff (reset) !(q_push && q_full));
    a_credit: assert property (@(posedge clk) disable iff (reset) in_flight <= (CNT_W + 1)'(QUEUE_DEPTH));
    a_drop_bound: assert property (@(posedge clk) disable iff (reset) drop_cnt <= outstanding);

endmodule

// File: tb/tb_stage_instruction_fetch.sv
// Randomized bench with an in-order memory model and a scoreboard of the expected instruction stream.
module tb_stage_instruction_fetch;
    import stage_instruction_fetch_pkg::*;

    localparam int          D   = 2;
    localparam logic [31:0] RPC = 32'h0000_0000;
    localparam logic [31:0] NOP = 32'h0000_0013;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        stall = 1'b0;
    logic        branch_decision = 1'b0;
    logic [31:0] branch_target = '0;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_gnt = 1'b0;
    logic        imem_rvalid = 1'b0;
    logic [31:0] imem_rdata = '0;
    logic        if_id_valid;
    logic [31:0] if_id_pc;
    logic [31:0] if_id_instruction;

    always #5 clk = ~clk;

    stage_instruction_fetch #(
        .RESET_PC   (RPC),
        .QUEUE_DEPTH(D)
    ) dut (
        .clk              (clk),
        .reset            (reset),
        .stall            (stall),
        .branch_decision  (branch_decision),
        .branch_target    (branch_target),
        .imem_req         (imem_req),
        .imem_addr        (imem_addr),
        .imem_gnt         (imem_gnt),
        .imem_rvalid      (imem_rvalid),
        .imem_rdata       (imem_rdata),
        .if_id_valid      (if_id_valid),
        .if_id_pc         (if_id_pc),
        .if_id_instruction(if_id_instruction)
    );

    int n_vec = 0;
    int n_bad = 0;
    int delivered = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return ~a ^ 32'h1357_9BDF;
    endfunction

    // Program-order stream the decode stage should see from the current fetch origin.
    logic [31:0] exp_q[$];
    logic        refill_pending = 1'b1;
    logic [31:0] refill_base = RPC;

    task automatic refill(input logic [31:0] base);
        logic [31:0] b;
        b = base & ~32'h3;
        exp_q.delete();
        for (int i = 0; i < 256; i++) exp_q.push_back(b + 32'(4 * i));
    endtask

    typedef struct {
        logic [31:0] addr;
        int          due;
    } mreq_t;
    mreq_t mq[$];
    logic  rnd_mode = 1'b0;

    // Stimulus and memory model.
    initial begin
        for (int t = -3; t < 1600; t++) begin
            @(posedge clk);
            if (refill_pending) begin
                refill(refill_base);
                refill_pending = 1'b0;
            end
            #1;
            rnd_mode = (t >= 80);
            reset = (t < 0) || (t == 1000) || (t == 1001);
            if (reset) begin
                mq.delete();
                refill_pending = 1'b1;
                refill_base = RPC;
            end
            imem_gnt = rnd_mode ? ($urandom_range(0, 9) < 7) : 1'b1;
            imem_rvalid = 1'b0;
            if (!reset && mq.size() > 0 && t >= mq[0].due &&
                (!rnd_mode || $urandom_range(0, 3) != 0)) begin
                imem_rvalid = 1'b1;
                imem_rdata = mem_word(mq[0].addr);
                void'(mq.pop_front());
            end
            stall = 1'b0;
            branch_decision = 1'b0;
            if (t >= 30 && t <= 32) stall = 1'b1;
            if (t == 40) begin branch_decision = 1'b1; branch_target = 32'h0000_0203; end
            if (t == 50 || t == 51) begin branch_decision = 1'b1; stall = 1'b1; branch_target = 32'h0000_0500; end
            if (t == 52) begin branch_decision = 1'b1; branch_target = 32'h0000_0500; end
            if (t == 60) begin branch_decision = 1'b1; branch_target = 32'hFFFF_FFF8; end
            if (rnd_mode) begin
                stall = ($urandom_range(0, 4) == 0);
                branch_decision = ($urandom_range(0, 15) == 0);
                case ($urandom_range(0, 2))
                    0: branch_target = $urandom;
                    1: branch_target = 32'hFFFF_FFF0 + $urandom_range(0, 15);
                    default: branch_target = $urandom_range(0, 4095);
                endcase
            end
            if (!reset && branch_decision && !stall) begin
                refill_pending = 1'b1;
                refill_base = branch_target;
            end
            @(negedge clk);
            if (reset) check("req_in_reset", {31'b0, imem_req}, 32'd0);
            if (!reset && imem_req && imem_gnt) begin
                check("addr_align", {30'b0, imem_addr[1:0]}, 32'd0);
                mq.push_back('{addr: imem_addr, due: t + (rnd_mode ? int'($urandom_range(1, 3)) : 1)});
            end
            if (!reset) check("outstanding_cap", 32'(mq.size() <= D), 32'd1);
            if (t >= 2 && t < 30) check("stream_valid", {31'b0, if_id_valid}, 32'd1);
            if (t == 31 || t == 32) check("req_drop_on_stall", {31'b0, imem_req}, 32'd0);
        end
        check("enough_delivered", 32'(delivered >= 150), 32'd1);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

    // Monitor: compares IF/ID against the scoreboard after every edge.
    logic        p_reset = 1'b1;
    logic        p_stall = 1'b0;
    logic        p_branch = 1'b0;
    logic        s_valid = 1'b0;
    logic [31:0] s_pc = '0;
    logic [31:0] s_instr = '0;
    int          idle = 0;

    initial begin
        logic [31:0] e;
        forever begin
            @(negedge clk);
            if (p_reset) begin
                check("reset_valid", {31'b0, if_id_valid}, 32'd0);
                check("reset_pc", if_id_pc, 32'd0);
                check("reset_instr", if_id_instruction, NOP);
                idle = 0;
            end else if (p_stall) begin
                check("stall_hold_valid", {31'b0, if_id_valid}, {31'b0, s_valid});
                check("stall_hold_pc", if_id_pc, s_pc);
                check("stall_hold_instr", if_id_instruction, s_instr);
            end else if (p_branch) begin
                check("redirect_bubble_valid", {31'b0, if_id_valid}, 32'd0);
                check("redirect_bubble_instr", if_id_instruction, NOP);
            end else if (if_id_valid) begin
                if (exp_q.size() == 0) begin
                    n_vec++;
                    n_bad++;
                    $display("FAIL scoreboard_empty: got pc %h, expected nothing", if_id_pc);
                end else begin
                    e = exp_q.pop_front();
                    check("if_id_pc", if_id_pc, e);
                    check("if_id_instr", if_id_instruction, mem_word(e));
                    delivered++;
                end
                idle = 0;
            end else begin
                check("bubble_instr", if_id_instruction, NOP);
                check("bubble_pc_hold", if_id_pc, s_pc);
                idle++;
                if (idle > 60) begin
                    n_vec++;
                    n_bad++;
                    $display("FAIL liveness: got %0d idle cycles, expected at most 60", idle);
                    idle = 0;
                end
            end
            p_reset  = reset;
            p_stall  = stall;
            p_branch = branch_decision;
            s_valid  = if_id_valid;
            s_pc     = if_id_pc;
            s_instr  = if_id_instruction;
        end
    end

endmodule
